// File: rtl/sample_window.sv
// Sliding-window collector: shifts accepted voltage samples into a WINDOW-deep
// register and presents a full window every STRIDE new samples via valid/ready.
module sample_window #(
  parameter int DATA_WIDTH = 32,
  parameter int WINDOW     = 8,
  parameter int STRIDE     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  output logic                         voltage_ready_in,
  input  logic                         voltage_valid_in,
  input  logic [DATA_WIDTH-1:0]        voltage_data_in,
  input  logic                         window_ready_out,
  output logic                         window_valid_out,
  output logic [WINDOW*DATA_WIDTH-1:0] window_data_out,
  output logic                         window_first_out
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam int WW = WINDOW * DATA_WIDTH;

  typedef enum logic {FILL, HOLD} state_t;

  state_t          state;
  logic [CW-1:0]   need_cnt;
  logic            first_pend;
  logic [WW-1:0]   win;
  logic            first;
  logic            accept;
  logic            take;
  logic            complete;

  assign window_valid_out = (state == HOLD);
  assign voltage_ready_in = ~window_valid_out | window_ready_out;
  assign accept           = voltage_valid_in & voltage_ready_in;
  assign take             = window_valid_out & window_ready_out;
  assign complete         = accept && (need_cnt == CW'(1));
  assign window_data_out  = win;
  assign window_first_out = first;

  // In HOLD an accept is only possible alongside a take, so completion
  // taking precedence over take covers the HOLD->HOLD back-to-back case.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      need_cnt   <= CW'(WINDOW);
      first      <= 1'b0;
      first_pend <= 1'b1;
      win        <= '0;
    end else if (flush) begin
      state      <= FILL;
      need_cnt   <= CW'(WINDOW);
      first      <= 1'b0;
      first_pend <= 1'b1;
    end else begin
      if (accept) begin
        win      <= {voltage_data_in, win[WW-1:DATA_WIDTH]};
        need_cnt <= complete ? CW'(STRIDE) : need_cnt - CW'(1);
      end
      if (complete) begin
        state      <= HOLD;
        first      <= first_pend;
        first_pend <= 1'b0;
      end else if (take) begin
        state <= FILL;
        first <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_window.sv
// Directed and throttled-random checks of sample_window with WINDOW=4,
// STRIDE=1 (dut a) and STRIDE=2 (dut b).
module tb_sample_window;
  localparam int DW = 16;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_flush, a_vin, a_rdy_out, a_rdy_in, a_valid, a_first;
  logic [DW-1:0] a_vdata;
  logic [63:0]   a_data;
  logic          b_flush, b_vin, b_rdy_out, b_rdy_in, b_valid, b_first;
  logic [DW-1:0] b_vdata;
  logic [63:0]   b_data;

  sample_window #(.DATA_WIDTH(DW), .WINDOW(W), .STRIDE(1)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .voltage_ready_in(a_rdy_in), .voltage_valid_in(a_vin), .voltage_data_in(a_vdata),
    .window_ready_out(a_rdy_out), .window_valid_out(a_valid),
    .window_data_out(a_data), .window_first_out(a_first));

  sample_window #(.DATA_WIDTH(DW), .WINDOW(W), .STRIDE(2)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .voltage_ready_in(b_rdy_in), .voltage_valid_in(b_vin), .voltage_data_in(b_vdata),
    .window_ready_out(b_rdy_out), .window_valid_out(b_valid),
    .window_data_out(b_data), .window_first_out(b_first));

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk4(input int s0, input int s1, input int s2, input int s3);
    logic [15:0] v0, v1, v2, v3;
    v0 = s0[15:0]; v1 = s1[15:0]; v2 = s2[15:0]; v3 = s3[15:0];
    return {v3, v2, v1, v0};
  endfunction

  task automatic reset_all();
    a_vin = 1'b0; b_vin = 1'b0; a_flush = 1'b0; b_flush = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [DW-1:0] hist[$];
  logic [63:0]   exp_win[$];
  logic          exp_first[$];
  logic [63:0]   mw;
  logic          mfirst, acc, tk, got_first;
  int            n, cyc;

  initial begin
    a_vdata = '0; b_vdata = '0; a_rdy_out = 1'b1; b_rdy_out = 1'b1;
    reset_all();
    // reset state
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_first", 64'(a_first), 64'd0);
    chk("rst_data", a_data, 64'd0);
    chk("rst_ready", 64'(a_rdy_in), 64'd1);
    chk("rst_b_valid", 64'(b_valid), 64'd0);

    // stride 1, back-to-back windows
    a_rdy_out = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      a_vin = 1'b1; a_vdata = DW'(k);
      tick();
      if (k >= 4) begin
        chk($sformatf("s1_valid_%0d", k), 64'(a_valid), 64'd1);
        chk($sformatf("s1_data_%0d", k), a_data, mk4(k-3, k-2, k-1, k));
        chk($sformatf("s1_first_%0d", k), 64'(a_first), 64'(k == 4));
      end else begin
        chk($sformatf("s1_fill_%0d", k), 64'(a_valid), 64'd0);
      end
    end
    a_vin = 1'b0;
    tick();
    chk("s1_drain", 64'(a_valid), 64'd0);

    // stride 2
    b_rdy_out = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      b_vin = 1'b1; b_vdata = DW'(k);
      tick();
      chk($sformatf("s2_valid_%0d", k), 64'(b_valid), 64'(k == 4 || k == 6 || k == 8));
      if (k == 4 || k == 6 || k == 8)
        chk($sformatf("s2_data_%0d", k), b_data, mk4(k-3, k-2, k-1, k));
    end
    b_vin = 1'b0;
    tick();
    chk("s2_drain", 64'(b_valid), 64'd0);

    // backpressure hold
    reset_all();
    a_rdy_out = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      a_vin = 1'b1; a_vdata = DW'(k);
      tick();
    end
    a_vdata = 16'd5;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_ready_%0d", c), 64'(a_rdy_in), 64'd0);
      chk($sformatf("bp_data_%0d", c), a_data, mk4(1, 2, 3, 4));
      chk($sformatf("bp_first_%0d", c), 64'(a_first), 64'd1);
      tick();
    end
    a_rdy_out = 1'b1;
    #1;
    chk("bp_ready_take", 64'(a_rdy_in), 64'd1);
    tick();
    a_vin = 1'b0;
    chk("bp_after_valid", 64'(a_valid), 64'd1);
    chk("bp_after_data", a_data, mk4(2, 3, 4, 5));
    chk("bp_after_first", 64'(a_first), 64'd0);
    tick();

    // flush drops in-flight sample and restarts fill
    reset_all();
    a_rdy_out = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      a_vin = 1'b1; a_vdata = DW'(k);
      tick();
    end
    a_flush = 1'b1; a_vdata = 16'd3;
    tick();
    a_flush = 1'b0;
    chk("fl_valid", 64'(a_valid), 64'd0);
    for (int k = 10; k <= 13; k++) begin
      a_vdata = DW'(k);
      tick();
      if (k < 13) chk($sformatf("fl_fill_%0d", k), 64'(a_valid), 64'd0);
    end
    a_vin = 1'b0;
    chk("fl_valid_win", 64'(a_valid), 64'd1);
    chk("fl_data", a_data, mk4(10, 11, 12, 13));
    chk("fl_first", 64'(a_first), 64'd1);
    tick();

    // reset with pending window
    reset_all();
    a_rdy_out = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      a_vin = 1'b1; a_vdata = DW'(k);
      tick();
    end
    a_vin = 1'b0;
    chk("rp_pending", 64'(a_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rp_valid", 64'(a_valid), 64'd0);
    chk("rp_first", 64'(a_first), 64'd0);
    chk("rp_data", a_data, 64'd0);
    chk("rp_ready", 64'(a_rdy_in), 64'd1);
    a_rdy_out = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      a_vin = 1'b1; a_vdata = DW'(20 + k);
      tick();
      chk($sformatf("rp_nowin_%0d", k), 64'(a_valid), 64'd0);
    end
    a_vin = 1'b0;
    tick();
    chk("rp_nowin_end", 64'(a_valid), 64'd0);

    // throttled random traffic on stride-2 instance vs sliding-window model
    reset_all();
    n = 0; cyc = 0; mfirst = 1'b1;
    while (n < 10000 && cyc < 60000) begin
      b_vin = ($urandom_range(0, 3) != 0);
      b_rdy_out = ($urandom_range(0, 3) != 0);
      b_vdata = DW'($urandom);
      #1;
      if (b_rdy_in !== (~b_valid | b_rdy_out))
        chk("rnd_ready", 64'(b_rdy_in), 64'(~b_valid | b_rdy_out));
      acc = b_vin & (~b_valid | b_rdy_out);
      tk = b_valid & b_rdy_out;
      if (tk) begin
        if (exp_win.size() == 0) begin
          chk("rnd_unexpected_window", 64'd1, 64'd0);
        end else begin
          chk("rnd_data", b_data, exp_win.pop_front());
          got_first = exp_first.pop_front();
          chk("rnd_first", 64'(b_first), 64'(got_first));
        end
      end
      if (acc) begin
        hist.push_back(b_vdata);
        if (hist.size() > W) void'(hist.pop_front());
        n++;
        if (n >= W && ((n - W) % 2) == 0) begin
          for (int unsigned i = 0; i < W; i++) mw[i*16 +: 16] = hist[i];
          exp_win.push_back(mw);
          exp_first.push_back(mfirst);
          mfirst = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    b_vin = 1'b0;
    chk("rnd_completed", 64'(n), 64'd10000);
    chk("rnd_pending", 64'(exp_win.size()), 64'(b_valid));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sample_window.md
SAMPLE_WINDOW -- requirements
Module: sample_window

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of one fixed-point voltage sample.
REQ-002 Parameter: WINDOW, 8, number of samples per output window (legal 2..64).
REQ-003 Parameter: STRIDE, 1, new samples between consecutive windows (legal 1..WINDOW).
REQ-004 Port: clk  input  1  clock; all logic on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: flush  input  1  synchronous restart of window fill without full reset.
REQ-007 Port: voltage_ready_in  output  1  block can accept a sample this cycle.
REQ-008 Port: voltage_valid_in  input  1  upstream sample valid.
REQ-009 Port: voltage_data_in  input  DATA_WIDTH  signed fixed-point voltage sample, passed through unmodified.
REQ-010 Port: window_ready_out  input  1  downstream (conv layer) can take a window.
REQ-011 Port: window_valid_out  output  1  window_data_out holds a complete window.
REQ-012 Port: window_data_out  output  WINDOW*DATA_WIDTH  window; slice [DATA_WIDTH-1:0] oldest sample, top slice newest.
REQ-013 Port: window_first_out  output  1  asserted with the first window after reset or flush.

Function
REQ-014 Input accept = voltage_valid_in & voltage_ready_in; output take = window_valid_out & window_ready_out.
REQ-015 voltage_ready_in shall equal ~window_valid_out | window_ready_out (combinational, no dependency on voltage_valid_in).
REQ-016 On accept, the window register shall shift one slot toward the oldest end and load voltage_data_in into the newest slot.
REQ-017 A down-counter need_cnt (width clog2(WINDOW+1)) shall hold samples still required before next window; load value WINDOW after reset/flush.
REQ-018 On accept with need_cnt > 1: need_cnt decrements, window_valid_out unchanged except cleared by take.
REQ-019 On accept with need_cnt == 1: window_valid_out set next cycle, need_cnt reloads STRIDE.
REQ-020 On take without accept-completing-a-window, window_valid_out clears next cycle.
REQ-021 Simultaneous take and window-completing accept: window_valid_out stays 1 with the new window (one window per cycle sustained when STRIDE=1).
REQ-022 Latency: window_valid_out asserts the cycle after the clock edge accepting the WINDOW-th sample after reset/flush; thereafter the cycle after each STRIDE-th further accepted sample.
REQ-023 While window_valid_out=1 and window_ready_out=0: window_data_out, window_first_out stable; voltage_ready_in=0; no sample accepted.
REQ-024 window_first_out set together with the first window after reset/flush; cleared on its take.
REQ-025 flush has priority over accept: on flush, window_valid_out and window_first_out clear, need_cnt reloads WINDOW, sample presented that cycle is dropped; window contents need not be cleared.
REQ-026 Two states: FILL (need_cnt counting, valid low) and HOLD (valid high); FILL->HOLD on window-completing accept, HOLD->FILL on take without completion, HOLD->HOLD on simultaneous take+completion.
REQ-027 No arithmetic on sample data; no sample is duplicated, reordered or dropped except under flush/reset.

Reset
REQ-028 On rst: window_valid_out=0, window_first_out=0, need_cnt=WINDOW, window register all zeros; voltage_ready_in=1 the cycle after reset deasserts.
REQ-029 rst mid-operation discards partial and pending windows identically to power-up reset; rst overrides flush.

Verification
REQ-030 WINDOW=4, STRIDE=1, ready held 1, samples 1..6 back-to-back -> windows {1,2,3,4},{2,3,4,5},{3,4,5,6} on consecutive cycles, first flag only on {1,2,3,4}.
REQ-031 WINDOW=4, STRIDE=2, samples 1..8 -> windows {1,2,3,4},{3,4,5,6},{5,6,7,8} only.
REQ-032 Window {1,2,3,4} valid, window_ready_out low 5 cycles with voltage_valid_in high -> voltage_ready_in=0, data stable, sample 5 accepted only on take cycle.
REQ-033 Flush after samples 1,2 while presenting 3 -> 3 dropped; samples 10..13 yield {10,11,12,13} with first flag.
REQ-034 rst asserted with window pending -> valid drops next cycle; 3 samples after reset produce no window.
REQ-035 Random valid/ready throttling, 10k samples -> scoreboard matches reference sliding-window model exactly.
